// File: rtl/verici_pkg.sv
// Shared constants and FSM state encoding for the differential symbol decoder.
package verici_pkg;
    localparam int SYM_W = 3;
    localparam logic [SYM_W-1:0] REF_INIT = 3'b001;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_SER,
        PROCESS
    } state_t;
endpackage

// File: rtl/verici_fark_hucre.sv
// Combinational 3-bit modular subtractor: diff = (cur - prev) mod 8.
module verici_fark_hucre
    import verici_pkg::*;
(
    input  logic [SYM_W-1:0] cur,
    input  logic [SYM_W-1:0] prev,
    output logic [SYM_W-1:0] diff
);
    assign diff = cur - prev;
endmodule

// File: rtl/verici_decoder.sv
// Differential decoder: word or serial symbols in, one symbol decoded per cycle, word or serial out.
// Latency G cycles (parallel in) or 2G-1 (serial in) to the bitti pulse; no backpressure.
module verici_decoder
    import verici_pkg::*;
#(
    parameter int N = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         basla,
    input  logic         mod1,
    input  logic         mod2,
    input  logic [N-1:0] gelen_veri,
    output logic [N-1:0] cikan_veri,
    output logic         bitti
);
    localparam int G  = N / SYM_W;
    localparam int CW = $clog2(G + 1);

    state_t           state_q, state_d;
    logic [N-1:0]     sym_q;
    logic [CW-1:0]    cnt_q;
    logic [SYM_W-1:0] ref_q;
    logic             mod2_q;
    logic [SYM_W-1:0] cur_sym;
    logic [SYM_W-1:0] diff;
    logic             last_cnt;

    // Symbols are kept MSB-group first and shifted up as they are consumed.
    assign cur_sym  = sym_q[N-1 -: SYM_W];
    assign last_cnt = (cnt_q == CW'(G - 1));

    verici_fark_hucre u_fark (
        .cur  (cur_sym),
        .prev (ref_q),
        .diff (diff)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (basla) begin
                    if (mod1 && G > 1) state_d = LOAD_SER;
                    else               state_d = PROCESS;
                end
            end
            LOAD_SER: begin
                if (basla && last_cnt) state_d = PROCESS;
            end
            PROCESS: begin
                if (last_cnt) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sym_q      <= '0;
            cnt_q      <= '0;
            ref_q      <= REF_INIT;
            mod2_q     <= 1'b0;
            cikan_veri <= '0;
            bitti      <= 1'b0;
        end else begin
            bitti <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (basla) begin
                        mod2_q <= mod2;
                        ref_q  <= REF_INIT;
                        if (mod1) begin
                            sym_q <= N'(gelen_veri[SYM_W-1:0]);
                            cnt_q <= (G > 1) ? CW'(1) : CW'(0);
                        end else begin
                            sym_q <= gelen_veri;
                            cnt_q <= '0;
                        end
                    end
                end
                LOAD_SER: begin
                    if (basla) begin
                        sym_q <= (sym_q << SYM_W) | N'(gelen_veri[SYM_W-1:0]);
                        cnt_q <= last_cnt ? '0 : cnt_q + 1'b1;
                    end
                end
                PROCESS: begin
                    sym_q <= sym_q << SYM_W;
                    ref_q <= cur_sym;
                    if (mod2_q) begin
                        cikan_veri <= N'(diff);
                    end else begin
                        for (int g = 0; g < G; g++) begin
                            if (cnt_q == CW'(g)) cikan_veri[N-1-SYM_W*g -: SYM_W] <= diff;
                        end
                    end
                    if (last_cnt) begin
                        bitti <= 1'b1;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_verici_decoder.sv
// Directed self-checking bench for verici_decoder with hand-computed expected words.
module tb_verici_decoder;
    localparam logic [11:0] W1 = 12'b011100010110;
    localparam logic [11:0] E1 = 12'b010001110100;
    localparam logic [11:0] W2 = 12'b101011001101;
    localparam logic [11:0] E2 = 12'b100110110100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        basla = 1'b0;
    logic        mod1 = 1'b0;
    logic        mod2 = 1'b0;
    logic [11:0] gelen_veri = '0;
    logic [11:0] cikan_veri;
    logic        bitti;

    int checks = 0;
    int errors = 0;

    verici_decoder #(.N(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .basla      (basla),
        .mod1       (mod1),
        .mod2       (mod2),
        .gelen_veri (gelen_veri),
        .cikan_veri (cikan_veri),
        .bitti      (bitti)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_par(input logic m2, input logic [11:0] w);
        mod1 = 1'b0;
        mod2 = m2;
        gelen_veri = w;
        basla = 1'b1;
        tick();
        basla = 1'b0;
        gelen_veri = 12'hfff;
    endtask

    // Leaves basla high after the last symbol; caller decides when to drop it.
    task automatic feed_ser(input logic m2, input logic [11:0] w, input int gap_after);
        logic [11:0] wv;
        wv = w;
        mod1 = 1'b1;
        mod2 = m2;
        for (int i = 0; i < 4; i++) begin
            gelen_veri = {9'b101010101, wv[11-3*i -: 3]};
            basla = 1'b1;
            tick();
            if (i == gap_after && i < 3) begin
                basla = 1'b0;
                gelen_veri = 12'h000;
                tick();
                tick();
            end
        end
    endtask

    task automatic wait_bitti(output int n);
        n = 0;
        while (bitti !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic collect_ser(input logic [11:0] e);
        logic [11:0] ev;
        ev = e;
        for (int j = 0; j < 4; j++) begin
            tick();
            basla = 1'b0;
            mod1 = ~mod1;
            mod2 = 1'b0;
            gelen_veri = 12'h5a5;
            check("ser_sym", 32'(cikan_veri[2:0]), 32'(ev[11-3*j -: 3]));
            check("ser_hi", 32'(cikan_veri[11:3]), 32'd0);
            check("ser_bitti", 32'(bitti), (j == 3) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        int n;
        int stray;

        rst = 1'b1;
        tick();
        tick();
        check("rst_out", 32'(cikan_veri), 32'd0);
        check("rst_bitti", 32'(bitti), 32'd0);
        rst = 1'b0;
        tick();

        // parallel in, parallel out
        start_par(1'b0, W1);
        wait_bitti(n);
        check("p_lat", 32'(n), 32'd4);
        check("p_res", 32'(cikan_veri), 32'(E1));
        tick();
        check("p_pulse", 32'(bitti), 32'd0);
        check("p_hold", 32'(cikan_veri), 32'(E1));
        tick();
        check("p_hold2", 32'(cikan_veri), 32'(E1));

        // serial in, parallel out after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_out", 32'(cikan_veri), 32'd0);
        feed_ser(1'b0, W1, 9);
        basla = 1'b0;
        wait_bitti(n);
        check("s_lat", 32'(n), 32'd4);
        check("s_res", 32'(cikan_veri), 32'(E1));

        // back-to-back: parallel in, serial out started on the bitti cycle
        start_par(1'b1, W1);
        collect_ser(E1);

        // serial in with a basla gap and an extra basla, serial out
        tick();
        feed_ser(1'b1, W1, 1);
        collect_ser(E1);

        // reference restart and wrap-around
        tick();
        start_par(1'b0, W2);
        wait_bitti(n);
        check("w_lat", 32'(n), 32'd4);
        check("w_res", 32'(cikan_veri), 32'(E2));

        // reset in the middle of PROCESS
        tick();
        start_par(1'b0, W1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out", 32'(cikan_veri), 32'd0);
        check("abort_bitti", 32'(bitti), 32'd0);
        stray = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bitti === 1'b1) stray++;
        end
        check("abort_nobitti", 32'(stray), 32'd0);
        check("abort_idle_out", 32'(cikan_veri), 32'd0);
        start_par(1'b0, W2);
        wait_bitti(n);
        check("after_lat", 32'(n), 32'd4);
        check("after_res", 32'(cikan_veri), 32'(E2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/verici_decoder.md
Name: verici_decoder

Overview:
- Receiver-side differential decoder for an N-bit word split into N/3 three-bit symbols, processed MSB group first.
- Each decoded symbol is (current received symbol − previous received symbol) mod 8. The first symbol uses a fixed reference of 3'b001.
- Input can arrive as a whole word or as one symbol per cycle (mod1). Output can be delivered as a whole word or as one symbol per cycle (mod2).
- Sits behind the link receiver; signals completion with a one-cycle bitti pulse.

Parameters:
- N, 12, word width in bits; must be a multiple of 3. G = N/3 symbols.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- basla  in  1  start. In serial-input mode it also qualifies each input symbol.
- mod1  in  1  input mode: 0 = parallel word, 1 = serial symbols on gelen_veri[2:0].
- mod2  in  1  output mode: 0 = parallel word, 1 = serial symbols on cikan_veri[2:0].
- gelen_veri  in  N  received data.
- cikan_veri  out  N  decoded data.
- bitti  out  1  done pulse.

Behaviour:
- Reset (synchronous, active-high): state IDLE, cikan_veri = 0, bitti = 0, counters cleared, reference = 3'b001. A reset mid-operation aborts the operation; no bitti is produced.
- Symbol numbering: symbol i (i = 0..G-1) is gelen_veri[N-1-3i -: 3].
- Decode rule: out_i = (in_i − in_{i−1}) mod 8, with in_{−1} = 3'b001. The reference restarts at 3'b001 on every new operation.
- States: IDLE, LOAD_SER, PROCESS.
- IDLE:
  - bitti = 0.
  - On an edge with basla=1, latch mod1 and mod2.
  - If mod1=0: capture the whole gelen_veri word and go to PROCESS.
  - If mod1=1: capture gelen_veri[2:0] as symbol 0 and go to LOAD_SER.
- LOAD_SER:
  - On each edge with basla=1, capture gelen_veri[2:0] as the next symbol.
  - After G symbols have been captured, go to PROCESS.
  - If basla drops early, stay in LOAD_SER; remaining symbols are taken on later basla=1 edges.
  - Extra basla cycles after G symbols are ignored.
- PROCESS: decode one symbol per cycle for G cycles, in MSB-group order.
  - mod2=0: write each decoded symbol into its group position of cikan_veri. On the cycle the last group is written, assert bitti.
  - mod2=1: drive cikan_veri[2:0] = decoded symbol each cycle, with cikan_veri[N-1:3] = 0. Assert bitti in the same cycle as the last symbol.
  - Then return to IDLE.
- Latency (mod1=0): basla sampled at edge k; bitti and the final result are visible after edge k+G.
- Latency (mod1=1): the last symbol is captured at edge k+G−1; bitti is visible after edge k+2G−1.
- bitti is high for exactly one cycle.
- cikan_veri holds its last value in IDLE until the next operation starts writing it or reset.
- A new basla is accepted on the very next edge after bitti.
- basla while in LOAD_SER is used only as the symbol qualifier. basla while in PROCESS is ignored. mod1, mod2 and gelen_veri changes while busy are ignored (except serial symbol capture).
- Arithmetic: 3-bit subtraction with natural wrap-around (e.g. 2−4 = 6).

Decomposition:
- Package verici_pkg:
  - SYM_W = 3.
  - REF_INIT = 3'b001.
  - State enum {IDLE, LOAD_SER, PROCESS}.
- Sub-module verici_fark_hucre: combinational 3-bit modular subtractor (cur, prev -> diff).
- Top level holds the FSM, symbol register, group counter and output register.

Test Plan:
- mod1=0, mod2=0, gelen_veri=12'b011100010110, basla for 1 cycle -> bitti pulse with cikan_veri=12'b010001110100, 4 cycles after capture.
- After reset, mod1=1, mod2=0, basla held 4 cycles with symbols 011, 100, 010, 110 -> bitti with cikan_veri=12'b010001110100.
- Immediately after the previous bitti (no reset), mod1=0, mod2=1, word 12'b011100010110 -> cikan_veri[2:0] sequence 010, 001, 110, 100, bitti coincident with 100, upper bits 0.
- mod1=1, mod2=1, symbols 011, 100, 010, 110 -> serial output 010, 001, 110, 100, bitti on the last symbol.
- mod1=0, mod2=0, gelen_veri=12'b101011001101 -> cikan_veri=12'b100110110100. Checks the reference restarts at 001 and that wrap-around holds (3−5 = 6).
- Assert rst mid-PROCESS, then start a new operation -> no bitti from the aborted run, outputs 0 after reset, new run's result correct.
